// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: widths, state encoding and the
// round-key XOR chain used once the G transform result is available.
package aes_pkg;

   localparam int AES_KEY_W      = 128;
   localparam int AES_WORD_W     = 32;
   localparam int AES_NUM_ROUNDS = 10;

   typedef enum logic [2:0] {
      KS_IDLE   = 3'd0,
      KS_ISSUE  = 3'd1,
      KS_WAIT_G = 3'd2,
      KS_EXPAND = 3'd3,
      KS_DONE   = 3'd4,
      KS_ERR    = 3'd5
   } ks_state_t;

   // Next round key from the previous one and the G word t = G(prev[31:0]).
   function automatic logic [AES_KEY_W-1:0] ks_xor_chain(
      input logic [AES_KEY_W-1:0]  prev_key,
      input logic [AES_WORD_W-1:0] t
   );
      logic [AES_WORD_W-1:0] w0;
      logic [AES_WORD_W-1:0] w1;
      logic [AES_WORD_W-1:0] w2;
      logic [AES_WORD_W-1:0] w3;
      w0 = prev_key[127:96] ^ t;
      w1 = prev_key[95:64]  ^ w0;
      w2 = prev_key[63:32]  ^ w1;
      w3 = prev_key[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/rk_regfile.sv
// Round-key register file: one write port, one registered read port.
// Cleared on reset so stale keys never survive an aborted expansion.
module rk_regfile #(
   parameter int DEPTH = 11,
   parameter int W     = 128,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [W-1:0] r_mem [0:DEPTH-1];
   logic [W-1:0] r_rdata;
   logic [DEPTH-1:0] w_row_we;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_row_dec
         assign w_row_we[gi] = i_we && (i_waddr == AW'(gi));
      end
   endgenerate

   // Row storage: each row loads when its decoded write enable is set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_row_we[i]) begin
               r_mem[i] <= i_wdata;
            end
         end
      end
   end

   // Registered read; addresses beyond the stored range return zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_raddr < AW'(DEPTH)) begin
         r_rdata <= r_mem[i_raddr];
      end else begin
         r_rdata <= '0;
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-expansion sequencer. Latches the cipher key, drives the external
// G word transform once per round and stores every round key for readback.
module key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
   parameter int G_TIMEOUT  = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         done,
   output logic         keys_valid,
   output logic         err,
   input  logic [3:0]   rk_rd_addr,
   output logic [127:0] rk_rd_data,
   output logic         g_enable,
   output logic [31:0]  g_input,
   output logic [3:0]   g_round,
   input  logic [31:0]  g_output,
   input  logic         g_done
);

   localparam int TMO_W = $clog2(G_TIMEOUT + 1);

   ks_state_t             r_state;
   logic [3:0]            r_round;
   logic [TMO_W-1:0]      r_tmo;
   logic [AES_WORD_W-1:0] r_t;
   logic [AES_KEY_W-1:0]  r_prev_key;
   logic [AES_WORD_W-1:0] r_g_input;
   logic                  r_keys_valid;
   logic                  r_err;

   logic                  w_idle_like;
   logic                  w_start_ok;
   logic [AES_KEY_W-1:0]  w_next_key;
   logic                  w_rf_we;
   logic [3:0]            w_rf_waddr;
   logic [AES_KEY_W-1:0]  w_rf_wdata;

   // Start is only honoured when no expansion is in flight.
   assign w_idle_like = (r_state == KS_IDLE) || (r_state == KS_DONE) || (r_state == KS_ERR);
   assign w_start_ok  = start && w_idle_like;

   // r_prev_key always mirrors rk[round-1], so EXPAND needs no file read.
   assign w_next_key = ks_xor_chain(r_prev_key, r_t);

   assign w_rf_we    = w_start_ok || (r_state == KS_EXPAND);
   assign w_rf_waddr = w_start_ok ? 4'd0 : r_round;
   assign w_rf_wdata = w_start_ok ? key_in : w_next_key;

   rk_regfile #(
      .DEPTH (NUM_ROUNDS + 1),
      .W     (AES_KEY_W),
      .AW    (4)
   ) u_rk_regfile (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_rf_we),
      .i_waddr (w_rf_waddr),
      .i_wdata (w_rf_wdata),
      .i_raddr (rk_rd_addr),
      .o_rdata (rk_rd_data)
   );

   // Sequencer: start -> (ISSUE -> WAIT_G -> EXPAND) per round -> DONE, or ERR on G timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= KS_IDLE;
         r_round      <= '0;
         r_tmo        <= '0;
         r_t          <= '0;
         r_prev_key   <= '0;
         r_g_input    <= '0;
         r_keys_valid <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            KS_IDLE, KS_DONE, KS_ERR: begin
               if (start) begin
                  r_prev_key   <= key_in;
                  r_g_input    <= key_in[31:0];
                  r_round      <= 4'd1;
                  r_err        <= 1'b0;
                  r_keys_valid <= 1'b0;
                  r_state      <= KS_ISSUE;
               end else if (r_state == KS_DONE) begin
                  r_keys_valid <= 1'b1;
                  r_state      <= KS_IDLE;
               end else if (r_state == KS_ERR) begin
                  r_err        <= 1'b1;
               end
            end
            KS_ISSUE: begin
               r_tmo   <= '0;
               r_state <= KS_WAIT_G;
            end
            KS_WAIT_G: begin
               if (g_done) begin
                  r_t     <= g_output;
                  r_state <= KS_EXPAND;
               end else if (r_tmo == TMO_W'(G_TIMEOUT - 1)) begin
                  r_state <= KS_ERR;
               end else begin
                  r_tmo   <= r_tmo + TMO_W'(1);
               end
            end
            KS_EXPAND: begin
               r_prev_key <= w_next_key;
               if (r_round == 4'(NUM_ROUNDS)) begin
                  r_state <= KS_DONE;
               end else begin
                  r_round   <= r_round + 4'd1;
                  r_g_input <= w_next_key[31:0];
                  r_state   <= KS_ISSUE;
               end
            end
            default: begin
               r_state <= KS_IDLE;
            end
         endcase
      end
   end

   assign busy       = (r_state == KS_ISSUE) || (r_state == KS_WAIT_G) || (r_state == KS_EXPAND);
   assign done       = (r_state == KS_DONE);
   assign g_enable   = (r_state == KS_ISSUE);
   assign g_input    = r_g_input;
   assign g_round    = r_round;
   assign keys_valid = r_keys_valid;
   assign err        = r_err;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with a behavioural G block (RotWord,
// SubWord, Rcon) of fixed latency, plus a reference key expansion.
module tb_key_sched_ctrl;

   localparam int G_LAT     = 12;
   localparam int G_TIMEOUT = 32;
   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic         clk;
   logic         rst;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic         err;
   logic [3:0]   rk_rd_addr;
   logic [127:0] rk_rd_data;
   logic         g_enable;
   logic [31:0]  g_input;
   logic [3:0]   g_round;
   logic [31:0]  g_output;
   logic         g_done;

   int           n_checks;
   int           n_errors;
   int           done_count;
   int           mon_round;
   logic         g_hang;
   logic [7:0]   sbox_tab [0:255];
   logic [127:0] exp_rk [0:10];

   logic [4:0]   gm_cnt;
   logic [31:0]  gm_word;
   logic [3:0]   gm_round;

   key_sched_ctrl #(
      .NUM_ROUNDS (10),
      .G_TIMEOUT  (G_TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .key_in     (key_in),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .err        (err),
      .rk_rd_addr (rk_rd_addr),
      .rk_rd_data (rk_rd_data),
      .g_enable   (g_enable),
      .g_input    (g_input),
      .g_round    (g_round),
      .g_output   (g_output),
      .g_done     (g_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("check %s ok: %h", tag, got);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xt(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      logic [7:0] yb;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            yb = y[7:0];
            if (gmul(x[7:0], yb) == 8'h01) inv = yb;
         end
         sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] g_fn(input logic [31:0] w, input logic [3:0] r);
      logic [31:0] rot;
      logic [31:0] s;
      logic [7:0]  rc;
      rot = {w[23:0], w[31:24]};
      s = {sbox_tab[rot[31:24]], sbox_tab[rot[23:16]], sbox_tab[rot[15:8]], sbox_tab[rot[7:0]]};
      rc = 8'h01;
      for (int i = 1; i < int'(r); i++) rc = xt(rc);
      return s ^ {rc, 24'h000000};
   endfunction

   task automatic build_expected(input logic [127:0] k);
      logic [31:0] w [0:43];
      logic [31:0] temp;
      for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         temp = w[i-1];
         if (i % 4 == 0) temp = g_fn(temp, 4'(i / 4));
         w[i] = w[i-4] ^ temp;
      end
      for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Behavioural G block: answers each request G_LAT cycles later.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         gm_cnt   <= '0;
         gm_word  <= '0;
         gm_round <= '0;
         g_done   <= 1'b0;
         g_output <= '0;
      end else begin
         g_done <= 1'b0;
         if (g_enable && !g_hang) begin
            gm_cnt   <= 5'(G_LAT);
            gm_word  <= g_input;
            gm_round <= g_round;
         end else if (gm_cnt != 0) begin
            gm_cnt <= gm_cnt - 5'd1;
            if (gm_cnt == 5'd1) begin
               g_done   <= 1'b1;
               g_output <= g_fn(gm_word, gm_round);
            end
         end
      end
   end

   // Request monitor: round sequence and the word handed to G.
   always @(negedge clk) begin
      if (g_enable) begin
         check_val("g_round", 128'(g_round), 128'(mon_round));
         if (mon_round >= 1 && mon_round <= 10) begin
            check_val("g_input", 128'(g_input), 128'(exp_rk[mon_round-1][31:0]));
         end
         if (mon_round == 1 && key_in == FIPS_KEY) begin
            check_val("g_input_r1", 128'(g_input), 128'h09cf4f3c);
         end
         mon_round++;
      end
      if (done) done_count++;
   end

   task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
      @(negedge clk);
      rk_rd_addr = a;
      @(posedge clk);
      #1;
      d = rk_rd_data;
   endtask

   task automatic do_start(input logic [127:0] k);
      @(negedge clk);
      key_in     = k;
      start      = 1'b1;
      rk_rd_addr = 4'd0;
      mon_round  = 1;
      done_count = 0;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (n < 400) begin
         @(posedge clk);
         #1;
         n++;
         if (done) break;
      end
      check_val("done_seen", 128'(done), 128'd1);
   endtask

   task automatic wait_round(input logic [3:0] r);
      int n;
      n = 0;
      while (!(g_round == r && busy) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_val("reach_round", 128'(g_round), 128'(r));
   endtask

   task automatic check_all_keys(input string tag);
      logic [127:0] d;
      for (int r = 0; r < 11; r++) begin
         read_rk(4'(r), d);
         check_val($sformatf("%s_rk%0d", tag, r), d, exp_rk[r]);
      end
   endtask

   initial begin
      int           n;
      logic [127:0] d;
      n_checks   = 0;
      n_errors   = 0;
      done_count = 0;
      mon_round  = 1;
      g_hang     = 1'b0;
      rst        = 1'b1;
      start      = 1'b0;
      key_in     = '0;
      rk_rd_addr = 4'd0;
      build_sbox();
      build_expected(FIPS_KEY);

      repeat (3) @(posedge clk);
      #1;
      check_val("rst_busy", 128'(busy), 128'd0);
      check_val("rst_done", 128'(done), 128'd0);
      check_val("rst_kv", 128'(keys_valid), 128'd0);
      check_val("rst_err", 128'(err), 128'd0);
      check_val("rst_g_en", 128'(g_enable), 128'd0);
      check_val("rst_g_in", 128'(g_input), 128'd0);
      check_val("rst_g_round", 128'(g_round), 128'd0);
      check_val("rst_rd_data", rk_rd_data, 128'd0);
      @(negedge clk);
      rst = 1'b0;

      // Test 1: full expansion of the FIPS-197 key.
      do_start(FIPS_KEY);
      @(posedge clk);
      #1;
      check_val("rd_addr0_after_start", rk_rd_data, FIPS_KEY);
      check_val("busy_running", 128'(busy), 128'd1);
      wait_done(n);
      check_val("expand_latency", 128'(n + 1), 128'(10 * (G_LAT + 3)));
      @(posedge clk);
      #1;
      check_val("kv_after_done", 128'(keys_valid), 128'd1);
      check_val("busy_after_done", 128'(busy), 128'd0);
      check_val("done_is_pulse", 128'(done), 128'd0);
      check_val("done_count_t1", 128'(done_count), 128'd1);
      read_rk(4'd1, d);
      check_val("fips_rk1", d, FIPS_RK1);
      read_rk(4'd10, d);
      check_val("fips_rk10", d, FIPS_RK10);
      check_all_keys("t1");
      for (int a = 11; a < 16; a++) begin
         read_rk(4'(a), d);
         check_val($sformatf("rd_oob_%0d", a), d, 128'd0);
      end

      // Test 2: start while busy at round 5 must be ignored.
      do_start(FIPS_KEY);
      wait_round(4'd5);
      @(negedge clk);
      key_in = {128{1'b1}};
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_val("busy_ignore_start", 128'(busy), 128'd1);
      check_val("round_ignore_start", 128'(g_round), 128'd5);
      wait_done(n);
      @(posedge clk);
      #1;
      check_val("kv_t2", 128'(keys_valid), 128'd1);
      check_val("done_count_t2", 128'(done_count), 128'd1);
      check_all_keys("t2");

      // Test 3: G never answers -> timeout abort, then recovery.
      g_hang = 1'b1;
      do_start(FIPS_KEY);
      n = 0;
      while (n < 100) begin
         @(posedge clk);
         #1;
         n++;
         if (err) break;
      end
      check_val("err_set", 128'(err), 128'd1);
      check_val("err_delay", 128'(n), 128'(G_TIMEOUT + 2));
      check_val("err_busy", 128'(busy), 128'd0);
      check_val("err_kv", 128'(keys_valid), 128'd0);
      @(posedge clk);
      #1;
      check_val("err_sticky", 128'(err), 128'd1);
      g_hang = 1'b0;
      do_start(FIPS_KEY);
      check_val("err_cleared", 128'(err), 128'd0);
      wait_done(n);
      @(posedge clk);
      #1;
      check_val("kv_t3", 128'(keys_valid), 128'd1);
      check_val("err_t3", 128'(err), 128'd0);
      check_val("done_count_t3", 128'(done_count), 128'd1);

      // Test 4: asynchronous reset in round 7, then restart.
      do_start(FIPS_KEY);
      wait_round(4'd7);
      #2;
      rst = 1'b1;
      #1;
      check_val("arst_busy", 128'(busy), 128'd0);
      check_val("arst_done", 128'(done), 128'd0);
      check_val("arst_kv", 128'(keys_valid), 128'd0);
      check_val("arst_err", 128'(err), 128'd0);
      check_val("arst_g_en", 128'(g_enable), 128'd0);
      check_val("arst_g_in", 128'(g_input), 128'd0);
      check_val("arst_g_round", 128'(g_round), 128'd0);
      check_val("arst_rd_data", rk_rd_data, 128'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      read_rk(4'd3, d);
      check_val("arst_rk3", d, 128'd0);
      do_start(FIPS_KEY);
      wait_done(n);
      @(posedge clk);
      #1;
      check_val("kv_t4", 128'(keys_valid), 128'd1);
      check_all_keys("t4");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
